token_inject_arbiter: RTL and testbench
=======================================

// Module: token_inject_arbiter
// PURPOSE
//  Shares the single token-injection channel (4-phase send/ack, 62-bit token) among NUM_REQ requesters.
//  Typical requesters: program loader (req 0) and runtime data injector (req 1+).
//  Grants round-robin per transaction. A requester may assert lock to keep the grant for a multi-token burst.
//  Sits between the requesters and the ring input port; it forwards one complete handshake at a time.
// PARAMETERS
//  NUM_REQ   2   number of requesters (2..8)
//  TOKEN_W   62  token width in bits
// PORTS
//  clk          in   1                clock
//  rst          in   1                asynchronous, active-high reset
//  req_send_i   in   NUM_REQ          per-requester send (4-phase)
//  req_lock_i   in   NUM_REQ          keep grant after current transaction
//  req_token_i  in   NUM_REQ*TOKEN_W  tokens; requester r at [r*TOKEN_W +: TOKEN_W]
//  req_ack_o    out  NUM_REQ          per-requester ack (only granted bit may be 1)
//  send_o       out  1                downstream send
//  token_o      out  TOKEN_W          downstream token, registered
//  ack_i        in   1                downstream ack
//  grant_o      out  $clog2(NUM_REQ)  index of current/last owner
//  busy_o       out  1                high in any state other than IDLE, or while locked
// BEHAVIOUR
//  - Reset (async, any state, including mid-handshake): all outputs 0; state IDLE; rr pointer 0; lock cleared.
//  - All outputs are registered. Each handshake phase below takes one clock edge after its condition is sampled.
//  - IDLE: pick a requester only when ack_i==0.
//      Candidates: requesters with req_send_i==1. While locked, the only candidate is the locked owner.
//      Pick = first candidate at or after rr pointer, wrapping. Several requests on the same cycle resolve this way.
//      On the pick edge: capture token_o <= req_token_i[g]; grant_o <= g; send_o <= 1; go SEND.
//  - SEND: wait for ack_i==1.
//      Then req_ack_o[g] <= 1; go ACK_UP.
//      token_o stays frozen, even if the requester changes its token.
//      If req_send_i[g] drops early, it is ignored; send_o stays 1.
//  - ACK_UP: wait for req_send_i[g]==0. Then send_o <= 0; go ACK_DN.
//  - ACK_DN: wait for ack_i==0. Then:
//      req_ack_o[g] <= 0.
//      rr pointer <= g+1, wrapping at NUM_REQ-1 -> 0.
//      lock <= req_lock_i[g], sampled on this edge.
//      Go IDLE.
//  - Latency: request -> send_o = 1 cycle. Handshake end -> earliest next send_o = 2 cycles (one IDLE cycle).
//  - Lock: while set, other requesters are starved. It clears at the end of the first owner transaction
//    that completes with req_lock_i[g]==0.
//      If the owner deasserts req_lock_i while idle with no pending send, lock clears in IDLE on the next edge.
//  - Invariants:
//      send_o==1 only in SEND and ACK_UP.
//      At most one req_ack_o bit is high.
//      req_ack_o never rises before ack_i.
//  - Unused state encodings go to IDLE with outputs cleared.
// STRUCTURE
//  - Shared package tokens_pkg:
//      TOKEN_W=62.
//      Arbiter state encoding IDLE=0, SEND=1, ACK_UP=2, ACK_DN=3.
//      4-phase handshake phase names, reused by the program loader.
//  - One sub-module: rr_pick (combinational).
//      Inputs: candidate vector, rr pointer.
//      Outputs: valid, index.
//  - Top: FSM, token register, ack/send registers, lock flag.
// TESTING
//  1. Single request, NUM_REQ=2:
//     req_send_i=01, token0=62'h180000026e000000, downstream acks after 3 cycles.
//     -> send_o high 1 cycle after request; token_o equals token0; req_ack_o=01 one cycle after ack_i.
//     -> Full 4-phase completes; grant_o=0.
//  2. Simultaneous requests, rr pointer=0:
//     req_send_i=11 held.
//     -> Req 0 served first, then req 1 (grant_o 0,1,0,1...).
//     -> Exactly one IDLE cycle between transactions; req_ack_o is never 11.
//  3. Lock burst:
//     req 0 sends 4 tokens (sysreg token 62'h1400000A00000000 last) with req_lock_i[0]=1 on the first 3;
//     req 1 pending throughout.
//     -> All 4 req-0 tokens are delivered before req 1's first send_o.
//  4. Held ack:
//     ack_i stuck high while IDLE and req_send_i=10.
//     -> No send_o until ack_i falls; then grant_o=1 and send_o rises 1 cycle later.
//  5. Reset mid-operation:
//     assert rst in ACK_UP with token 62'h1800200040000000 in flight.
//     -> send_o, req_ack_o, busy_o go 0 immediately (async).
//     -> After release, the next request is granted from pointer 0.
//  6. Token stability:
//     the requester changes req_token_i while in SEND.
//     -> token_o keeps the captured value until the handshake completes.

Source files
------------

// File: rtl/tokens_pkg.sv
// Shared token-channel definitions: token width, arbiter state encoding and
// 4-phase handshake phase names used by the arbiter and the program loader.
package tokens_pkg;

    localparam int TOKEN_W = 62;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        ACK_UP = 2'd2,
        ACK_DN = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_SEND    = 2'd1,
        HS_ACK     = 2'd2,
        HS_RELEASE = 2'd3
    } hs_phase_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr,
// wrapping at NUM_REQ-1.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] cand,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] rot;
    logic [IDX_W:0]       sum;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        // Rotating a doubled vector puts the candidate at ptr+i on bit i.
        rot   = {cand, cand} >> ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/token_inject_arbiter.sv
// Round-robin arbiter sharing the 4-phase token-injection channel among
// NUM_REQ requesters, with per-owner lock for multi-token bursts.
module token_inject_arbiter
    import tokens_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TOKEN_W = tokens_pkg::TOKEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_send_i,
    input  logic [NUM_REQ-1:0]           req_lock_i,
    input  logic [NUM_REQ*TOKEN_W-1:0]   req_token_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic                         send_o,
    output logic [TOKEN_W-1:0]           token_o,
    input  logic                         ack_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_o,
    output logic                         busy_o
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t          state_q, state_n;
    logic [TOKEN_W-1:0]  token_n;
    logic [GW-1:0]       grant_n;
    logic                send_n;
    logic [NUM_REQ-1:0]  ack_n;
    logic                busy_n;
    logic [GW-1:0]       rr_q, rr_n;
    logic                lock_q, lock_n;

    logic [TOKEN_W-1:0]  tok_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  cand;
    logic                pick_valid;
    logic [GW-1:0]       pick_idx;
    logic                own_send;
    logic                own_lock;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tok_arr[i] = req_token_i[i*TOKEN_W +: TOKEN_W];
        end
    end

    assign owner_mask = NUM_REQ'(1) << grant_o;
    assign own_send   = |(req_send_i & owner_mask);
    assign own_lock   = |(req_lock_i & owner_mask);
    // While locked the owner is the only candidate, so the pointer is moot.
    assign cand       = lock_q ? (req_send_i & owner_mask) : req_send_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GW)
    ) u_rr_pick (
        .cand  (cand),
        .ptr   (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state_q;
        token_n = token_o;
        grant_n = grant_o;
        send_n  = send_o;
        ack_n   = req_ack_o;
        rr_n    = rr_q;
        lock_n  = lock_q;
        unique case (state_q)
            IDLE: begin
                if (!ack_i && pick_valid) begin
                    token_n = tok_arr[pick_idx];
                    grant_n = pick_idx;
                    send_n  = 1'b1;
                    state_n = SEND;
                end else if (lock_q && !own_lock && !own_send) begin
                    lock_n = 1'b0;
                end
            end
            SEND: begin
                if (ack_i) begin
                    ack_n   = owner_mask;
                    state_n = ACK_UP;
                end
            end
            ACK_UP: begin
                if (!own_send) begin
                    send_n  = 1'b0;
                    state_n = ACK_DN;
                end
            end
            ACK_DN: begin
                if (!ack_i) begin
                    ack_n   = '0;
                    rr_n    = (grant_o == GW'(NUM_REQ-1)) ? '0 : grant_o + 1'b1;
                    lock_n  = own_lock;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                token_n = '0;
                grant_n = '0;
                send_n  = 1'b0;
                ack_n   = '0;
                lock_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE) || lock_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            token_o   <= '0;
            grant_o   <= '0;
            send_o    <= 1'b0;
            req_ack_o <= '0;
            busy_o    <= 1'b0;
            rr_q      <= '0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            token_o   <= token_n;
            grant_o   <= grant_n;
            send_o    <= send_n;
            req_ack_o <= ack_n;
            busy_o    <= busy_n;
            rr_q      <= rr_n;
            lock_q    <= lock_n;
        end
    end

endmodule

// File: tb/tb_token_inject_arbiter.sv
// Directed self-checking bench for token_inject_arbiter with NUM_REQ=2.
module tb_token_inject_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_send = '0;
    logic [1:0]    req_lock = '0;
    logic [123:0]  req_token = '0;
    logic [1:0]    req_ack;
    logic          send_o;
    logic [61:0]   token_o;
    logic          ack_i = 1'b0;
    logic [0:0]    grant_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    token_inject_arbiter #(
        .NUM_REQ (2),
        .TOKEN_W (62)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_send_i  (req_send),
        .req_lock_i  (req_lock),
        .req_token_i (req_token),
        .req_ack_o   (req_ack),
        .send_o      (send_o),
        .token_o     (token_o),
        .ack_i       (ack_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ack_i    = 1'b0;
        req_send = '0;
        req_lock = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full 4-phase transaction for requester r, downstream acks 3 cycles after send_o.
    task automatic serve(input int r, input logic [61:0] tok, input logic lk,
                         input logic reraise, input logic exp_busy_after);
        logic [1:0] onehot;
        onehot = 2'b01 << r;
        ack_i = 1'b0;
        req_token[r*62 +: 62] = tok;
        req_lock[r] = lk;
        req_send[r] = 1'b1;
        tick();
        check("send_rise", send_o, 1);
        check("grant_pick", grant_o, r);
        check("token_capture", token_o, tok);
        check("ack_before_down", req_ack, 0);
        req_token[r*62 +: 62] = ~tok;
        tick();
        check("ack_not_early", req_ack, 0);
        tick();
        check("send_held", send_o, 1);
        ack_i = 1'b1;
        tick();
        check("req_ack_up", req_ack, onehot);
        check("token_frozen", token_o, tok);
        req_send[r] = 1'b0;
        tick();
        check("send_fall", send_o, 0);
        check("req_ack_held", req_ack, onehot);
        check("busy_mid", busy_o, 1);
        ack_i = 1'b0;
        tick();
        check("req_ack_down", req_ack, 0);
        check("busy_after", busy_o, exp_busy_after);
        check("grant_kept", grant_o, r);
        check("token_after", token_o, tok);
        if (reraise) req_send[r] = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_send", send_o, 0);
        check("rst_ack", req_ack, 0);
        check("rst_token", token_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);

        // 1. Single request
        serve(0, 62'h180000026e000000, 1'b0, 1'b0, 1'b0);
        tick();
        check("t1_idle_send", send_o, 0);

        // 2. Simultaneous requests alternate from pointer 0
        do_reset();
        req_send = 2'b11;
        serve(0, 62'h0000000000000a01, 1'b0, 1'b1, 1'b0);
        serve(1, 62'h0000000000000b01, 1'b0, 1'b1, 1'b0);
        serve(0, 62'h0000000000000a02, 1'b0, 1'b1, 1'b0);
        serve(1, 62'h0000000000000b02, 1'b0, 1'b0, 1'b0);
        req_send = '0;
        tick();
        check("t2_idle", send_o, 0);

        // 3. Lock burst: req 1 pending throughout, starved until burst ends
        do_reset();
        req_send[1] = 1'b1;
        req_token[62 +: 62] = 62'h0000000000000bbb;
        serve(0, 62'h0000000000000111, 1'b1, 1'b1, 1'b1);
        serve(0, 62'h0000000000000222, 1'b1, 1'b1, 1'b1);
        serve(0, 62'h0000000000000333, 1'b1, 1'b1, 1'b1);
        serve(0, 62'h1400000A00000000, 1'b0, 1'b0, 1'b0);
        serve(1, 62'h0000000000000bbb, 1'b0, 1'b0, 1'b0);

        // Lock released while idle with nothing pending
        do_reset();
        serve(0, 62'h0000000000000444, 1'b1, 1'b0, 1'b1);
        tick();
        check("lock_hold_idle", busy_o, 1);
        req_lock[0] = 1'b0;
        tick();
        check("lock_clear_idle", busy_o, 0);

        // 4. Held ack blocks the pick
        do_reset();
        ack_i = 1'b1;
        req_send = 2'b10;
        req_token[62 +: 62] = 62'h0000000000000ccc;
        tick();
        check("held_ack_0", send_o, 0);
        tick();
        check("held_ack_1", send_o, 0);
        tick();
        check("held_ack_2", send_o, 0);
        check("held_ack_busy", busy_o, 0);
        serve(1, 62'h0000000000000ccc, 1'b0, 1'b0, 1'b0);

        // 5. Async reset in ACK_UP, then pointer restarts at 0
        do_reset();
        serve(0, 62'h0000000000000555, 1'b0, 1'b0, 1'b0);
        req_token[62 +: 62] = 62'h1800200040000000;
        req_send = 2'b10;
        tick();
        check("t5_send", send_o, 1);
        check("t5_grant", grant_o, 1);
        ack_i = 1'b1;
        tick();
        check("t5_ack_up", req_ack, 2'b10);
        rst = 1'b1;
        #1;
        check("t5_async_send", send_o, 0);
        check("t5_async_ack", req_ack, 0);
        check("t5_async_busy", busy_o, 0);
        check("t5_async_token", token_o, 0);
        ack_i = 1'b0;
        req_send = '0;
        tick();
        tick();
        rst = 1'b0;
        req_send = 2'b10;
        serve(0, 62'h0000000000000666, 1'b0, 1'b0, 1'b0);
        req_send = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
